// File: rtl/vga_timing_driver_if.sv
// Pixel-coordinate bus shared with the drawing units, plus the VGA DAC pins.
// master = timing driver, slave = video chain / board.
interface vga_timing_driver_if;
  logic [7:0]  RGBIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        startOfFrame;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  modport master (
    input  RGBIn,
    output pixelX, pixelY, startOfFrame,
    output VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output RGBIn,
    input  pixelX, pixelY, startOfFrame,
    input  VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_driver.sv
// VGA raster timing: publishes pixel coordinates, delays sync/blank to meet the
// pipelined RGB stream, and expands 3:3:2 colour to 8:8:8 for the DAC.
module vga_timing_driver #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int PIPE_DELAY = 2
) (
  input  logic                clk,
  input  logic                resetN,
  vga_timing_driver_if.master vga
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  // {visible, hs_n, vs_n}: blanked with both syncs inactive
  localparam logic [2:0] DEC_IDLE = 3'b011;

  logic [10:0] hCnt_q, hCnt_d, vCnt_q, vCnt_d;
  logic [10:0] pixelX_q, pixelY_q;
  logic        sof_q;
  logic [2:0]  dec_q, dec_d, dly;

  always_comb begin
    hCnt_d = hCnt_q + 11'd1;
    vCnt_d = vCnt_q;
    if (hCnt_q == H_LAST) begin
      hCnt_d = '0;
      vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + 11'd1;
    end
  end

  // Decode is registered next to pixelX/Y so the reset coordinate never
  // leaks into the delay line as a visible pixel.
  always_comb begin
    dec_d[2] = (hCnt_q < H_VIS) && (vCnt_q < V_VIS);
    dec_d[1] = !((hCnt_q >= HS_BEG) && (hCnt_q < HS_END));
    dec_d[0] = !((vCnt_q >= VS_BEG) && (vCnt_q < VS_END));
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hCnt_q   <= '0;
      vCnt_q   <= '0;
      pixelX_q <= '0;
      pixelY_q <= '0;
      sof_q    <= 1'b0;
      dec_q    <= DEC_IDLE;
    end else begin
      hCnt_q   <= hCnt_d;
      vCnt_q   <= vCnt_d;
      pixelX_q <= hCnt_q;
      pixelY_q <= vCnt_q;
      sof_q    <= (hCnt_q == '0) && (vCnt_q == '0);
      dec_q    <= dec_d;
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign dly = dec_q;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0][2:0] pipe_q;
      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          pipe_q <= {PIPE_DELAY{DEC_IDLE}};
        end else begin
          pipe_q[0] <= dec_q;
          for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign dly = pipe_q[PIPE_DELAY-1];
    end
  endgenerate

  logic       blank_q, blank_d, hs_q, hs_d, vs_q, vs_d;
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;

  // Bit replication gives full-scale expansion: max code -> 0xFF.
  always_comb begin
    blank_d = dly[2];
    hs_d    = dly[1];
    vs_d    = dly[0];
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    if (dly[2]) begin
      r_d = {vga.RGBIn[7:5], vga.RGBIn[7:5], vga.RGBIn[7:6]};
      g_d = {vga.RGBIn[4:2], vga.RGBIn[4:2], vga.RGBIn[4:3]};
      b_d = {4{vga.RGBIn[1:0]}};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign vga.pixelX       = pixelX_q;
  assign vga.pixelY       = pixelY_q;
  assign vga.startOfFrame = sof_q;
  assign vga.VGA_HS       = hs_q;
  assign vga.VGA_VS       = vs_q;
  assign vga.VGA_BLANK_N  = blank_q;
  assign vga.VGA_SYNC_N   = 1'b0;
  assign vga.VGA_R        = r_q;
  assign vga.VGA_G        = g_q;
  assign vga.VGA_B        = b_q;
endmodule
